// File: rtl/tlc549_reader_pkg.sv
// Shared definitions for the TLC549 serial ADC reader: state encodings,
// default timing constants and the ADC result width.
package tlc549_reader_pkg;

    localparam int ADC_BITS     = 8;
    localparam int CLK_HALF_DEF = 25;    // 50 MHz / (2*25) = 1 MHz I/O clock
    localparam int T_SETUP_DEF  = 100;   // 2 us CS-low setup window
    localparam int T_CONV_DEF   = 1000;  // 20 us conversion wait

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CONV  = 3'd4
    } state_t;

endpackage

// File: rtl/tlc549_reader_ad_clk_gen.sv
// ADC I/O clock generator: toggles ad_clk every CLK_HALF cycles while
// enabled, first toggle is a rise. rise/fall strobe on the cycle whose
// closing edge makes ad_clk go 0->1 / 1->0. Held low when disabled.
module ad_clk_gen
    import tlc549_reader_pkg::*;
#(
    parameter int CLK_HALF = CLK_HALF_DEF
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic en,
    output logic ad_clk,
    output logic rise,
    output logic fall
);

    localparam int HW = $clog2(CLK_HALF) + 1;

    logic [HW-1:0] half_cnt;
    logic          half_done;

    assign half_done = en && (half_cnt == HW'(CLK_HALF - 1));
    assign rise      = half_done && !ad_clk;
    assign fall      = half_done && ad_clk;

    // Half-period counter; clears and toggles the clock at each half boundary
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            half_cnt <= '0;
            ad_clk   <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            ad_clk   <= 1'b0;
        end else if (half_done) begin
            half_cnt <= '0;
            ad_clk   <= ~ad_clk;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tlc549_reader.sv
// TLC549 serial ADC reader. Runs CS / I/O clock / MSB-first shift-in,
// waits out the conversion time and presents each sample with a 1-cycle
// sample_valid pulse. The first frame after reset carries a stale result
// and is dropped silently.
// Build option: ADC_AUTO_EN -- free-running conversions, sample_start unused.
module tlc549_reader
    import tlc549_reader_pkg::*;
#(
    parameter int CLK_HALF = CLK_HALF_DEF,
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_CONV   = T_CONV_DEF
) (
    input  logic                CLK_50M,
    input  logic                RST_N,
    output logic                AD_CLK,
    output logic                AD_CS,
    input  logic                AD_DOUT,
    input  logic                sample_start,
    output logic [ADC_BITS-1:0] ad_data,
    output logic                sample_valid,
    output logic                busy
);

    localparam int TMAX = (T_CONV > T_SETUP) ? T_CONV : T_SETUP;
    localparam int TW   = $clog2(TMAX) + 1;

    state_t              state;
    logic [TW-1:0]       tcnt;
    logic [3:0]          bit_cnt;
    logic [ADC_BITS-1:0] shift_reg;
    logic                first_frame;
    logic                dout_meta, dout_s;
    logic                clk_rise, clk_fall;
    logic                go;

`ifdef ADC_AUTO_EN
    // Free-running: every IDLE cycle launches the next frame; sample_start has no effect
    assign go = 1'b1 | sample_start;
`else
    assign go = sample_start;
`endif

    assign busy = (state != ST_IDLE);

    ad_clk_gen #(.CLK_HALF(CLK_HALF)) u_clk_gen (
        .CLK_50M (CLK_50M),
        .RST_N   (RST_N),
        .en      (state == ST_SHIFT),
        .ad_clk  (AD_CLK),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    // Two-flop synchronizer on the asynchronous ADC data line
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            dout_meta <= 1'b0;
            dout_s    <= 1'b0;
        end else begin
            dout_meta <= AD_DOUT;
            dout_s    <= dout_meta;
        end
    end

    // Frame FSM: CS control, bit capture, conversion wait and sample output
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            AD_CS        <= 1'b1;
            tcnt         <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            ad_data      <= '0;
            sample_valid <= 1'b0;
            first_frame  <= 1'b1;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tcnt    <= '0;
                    bit_cnt <= '0;
                    if (go) begin
                        state <= ST_SETUP;
                        AD_CS <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tcnt == TW'(T_SETUP - 1)) begin
                        tcnt  <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Bit timing lives in the clock generator's half counter
                    tcnt <= '0;
                    if (clk_rise) begin
                        shift_reg <= {shift_reg[ADC_BITS-2:0], dout_s};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    if (clk_fall && bit_cnt == 4'(ADC_BITS)) begin
                        state <= ST_CONV;
                        AD_CS <= 1'b1;
                        if (first_frame) begin
                            first_frame <= 1'b0;
                        end else begin
                            ad_data      <= shift_reg;
                            sample_valid <= 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    if (tcnt == TW'(T_CONV - 1)) begin
                        tcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    AD_CS <= 1'b1;
                    tcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlc549_reader.sv
// Bench for tlc549_reader: TLC549 behavioural model plus a scoreboard of
// expected samples (pushed at CS fall, popped on sample_valid).
module tb_tlc549_reader;

    localparam int CLK_HALF = 25;
    localparam int T_SETUP  = 100;
    localparam int T_CONV   = 1000;
    localparam int FRAME    = 1 + T_SETUP + 16 * CLK_HALF + T_CONV;
    localparam int WAIT_MAX = 4000;

    logic       CLK_50M = 1'b0;
    logic       RST_N = 1'b0;
    logic       AD_CLK, AD_CS, AD_DOUT;
    logic       sample_start = 1'b0;
    logic [7:0] ad_data;
    logic       sample_valid, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int npulse = 0;

    tlc549_reader #(.CLK_HALF(CLK_HALF), .T_SETUP(T_SETUP), .T_CONV(T_CONV)) dut (
        .CLK_50M      (CLK_50M),
        .RST_N        (RST_N),
        .AD_CLK       (AD_CLK),
        .AD_CS        (AD_CS),
        .AD_DOUT      (AD_DOUT),
        .sample_start (sample_start),
        .ad_data      (ad_data),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #10 CLK_50M = ~CLK_50M;

    // TLC549 model: outputs the previous conversion, MSB at CS fall,
    // next bit after each I/O clock fall; converts on CS rise.
    logic [7:0] analog = 8'h00;
    logic [7:0] conv_reg = 8'h00;
    logic [7:0] out_sr = 8'h00;
    logic       dout_m = 1'b0;
    bit         discard = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp = 8'h00;
    logic       prev_valid = 1'b0;

    assign AD_DOUT = dout_m;

    always @(negedge AD_CS) begin
        out_sr = conv_reg;
        dout_m = out_sr[7];
        if (discard) discard = 1'b0;
        else exp_q.push_back(conv_reg);
    end

    always @(negedge AD_CLK) begin
        if (AD_CS === 1'b0) begin
            out_sr = {out_sr[6:0], 1'b0};
            dout_m = out_sr[7];
        end
    end

    always @(posedge AD_CS) conv_reg = analog;

    // Scoreboard: pop on each valid pulse, otherwise ad_data must hold
    always @(negedge CLK_50M) begin
        if (RST_N) begin
            if (sample_valid) begin
                npulse++;
                n_cmp++;
                if (prev_valid) begin
                    n_bad++;
                    $display("FAIL valid_width: sample_valid high 2 cycles running, required 1");
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid: pulse with ad_data=%h, none required", ad_data);
                end else begin
                    last_exp = exp_q.pop_front();
                    if (ad_data !== last_exp) begin
                        n_bad++;
                        $display("FAIL sample_data: ad_data=%h required %h", ad_data, last_exp);
                    end
                end
            end else begin
                n_cmp++;
                if (ad_data !== last_exp) begin
                    n_bad++;
                    if (n_bad < 20) $display("FAIL data_hold: ad_data=%h required %h", ad_data, last_exp);
                end
            end
        end
        prev_valid = sample_valid;
    end

    task automatic enter_reset();
        RST_N    = 1'b0;
        exp_q.delete();
        discard  = 1'b1;
        last_exp = 8'h00;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < WAIT_MAX) begin
            @(negedge CLK_50M);
            cyc++;
        end
    endtask

    task automatic run_frame();
        int c;
        @(negedge CLK_50M) sample_start = 1'b1;
        @(negedge CLK_50M) sample_start = 1'b0;
        wait_idle(c);
        n_cmp++;
        if (c >= WAIT_MAX) begin
            n_bad++;
            $display("FAIL frame_timeout: busy still high after %0d cycles, required < %0d", c, WAIT_MAX);
        end
    endtask

    task automatic test_reset();
        enter_reset();
        repeat (3) @(negedge CLK_50M);
        n_cmp += 5;
        if (AD_CS !== 1'b1)        begin n_bad++; $display("FAIL rst_cs: AD_CS=%b required 1", AD_CS); end
        if (AD_CLK !== 1'b0)       begin n_bad++; $display("FAIL rst_clk: AD_CLK=%b required 0", AD_CLK); end
        if (ad_data !== 8'h00)     begin n_bad++; $display("FAIL rst_data: ad_data=%h required 00", ad_data); end
        if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: sample_valid=%b required 0", sample_valid); end
        if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy: busy=%b required 0", busy); end
        RST_N = 1'b1;
`ifndef ADC_AUTO_EN
        repeat (5) @(negedge CLK_50M);
        n_cmp++;
        if (busy !== 1'b0 || AD_CS !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_hold: busy=%b AD_CS=%b required 0/1 without start", busy, AD_CS);
        end
`endif
    endtask

`ifndef ADC_AUTO_EN
    task automatic test_first_frame();
        int p0;
        analog = 8'hA5;
        enter_reset();
        repeat (2) @(negedge CLK_50M);
        RST_N = 1'b1;
        p0 = npulse;
        run_frame();
        n_cmp++;
        if (npulse - p0 != 0) begin n_bad++; $display("FAIL first_frame_drop: %0d pulses required 0", npulse - p0); end
        run_frame();
        n_cmp += 3;
        if (npulse - p0 != 1) begin n_bad++; $display("FAIL second_frame_pulse: %0d pulses required 1", npulse - p0); end
        if (ad_data !== 8'hA5) begin n_bad++; $display("FAIL second_frame_data: ad_data=%h required a5", ad_data); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL first_queue: %0d samples outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_timing();
        int  nfall = 0, nrise = 0, per_bad = 0, c;
        int  cs_fall0 = -1, cs_fall1 = -1, cs_rise = -1, first_rise = -1, last_rise = -1, last_fall = -1;
        logic pcs, pclk;
        pcs  = AD_CS;
        pclk = AD_CLK;
        @(negedge CLK_50M) sample_start = 1'b1;
        for (int i = 0; i < 2 * FRAME + 200 && nfall < 2; i++) begin
            @(negedge CLK_50M);
            if (pcs && !AD_CS) begin
                if (nfall == 0) cs_fall0 = i; else cs_fall1 = i;
                nfall++;
            end
            if (nfall == 1 && cs_rise < 0) begin
                if (!pclk && AD_CLK) begin
                    if (nrise == 0) first_rise = i;
                    else if (i - last_rise != 2 * CLK_HALF) per_bad++;
                    last_rise = i;
                    nrise++;
                end
                if (pclk && !AD_CLK) last_fall = i;
                if (!pcs && AD_CS) cs_rise = i;
            end
            pcs  = AD_CS;
            pclk = AD_CLK;
        end
        sample_start = 1'b0;
        wait_idle(c);
        n_cmp += 7;
        if (nfall != 2)   begin n_bad++; $display("FAIL cs_falls: %0d seen required 2", nfall); end
        if (nrise != 8)   begin n_bad++; $display("FAIL clk_rises: %0d seen required 8", nrise); end
        if (per_bad != 0) begin n_bad++; $display("FAIL clk_period: %0d periods off, required period %0d", per_bad, 2 * CLK_HALF); end
        if (first_rise - cs_fall0 != T_SETUP + CLK_HALF)
            begin n_bad++; $display("FAIL cs_to_rise: %0d cycles required %0d", first_rise - cs_fall0, T_SETUP + CLK_HALF); end
        if (cs_rise - last_fall > 1 || cs_rise < last_fall)
            begin n_bad++; $display("FAIL fall_to_cs: %0d cycles required 0..1", cs_rise - last_fall); end
        if (cs_fall1 - cs_rise != T_CONV + 1)
            begin n_bad++; $display("FAIL cs_high: %0d cycles required %0d", cs_fall1 - cs_rise, T_CONV + 1); end
        if (cs_fall1 - cs_fall0 != FRAME)
            begin n_bad++; $display("FAIL frame_len: %0d cycles required %0d", cs_fall1 - cs_fall0, FRAME); end
        n_cmp++;
        if (c >= WAIT_MAX) begin n_bad++; $display("FAIL timing_timeout: busy high %0d cycles", c); end
    endtask

    task automatic test_busy_ignore();
        int p0, hi;
        p0 = npulse;
        @(negedge CLK_50M) sample_start = 1'b1;
        @(negedge CLK_50M) sample_start = 1'b0;
        hi = (busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge CLK_50M);
            sample_start = (k == 299);
            if (busy === 1'b1) hi++;
            else break;
        end
        sample_start = 1'b0;
        repeat (20) @(negedge CLK_50M);
        n_cmp += 3;
        if (hi != FRAME - 1) begin n_bad++; $display("FAIL busy_len: busy high %0d cycles required %0d", hi, FRAME - 1); end
        if (busy !== 1'b0)   begin n_bad++; $display("FAIL start_queued: busy=%b after frame required 0", busy); end
        if (npulse - p0 != 1) begin n_bad++; $display("FAIL ignore_count: %0d pulses required 1", npulse - p0); end
    endtask

    task automatic test_reset_midframe();
        int   p0, nr = 0, k;
        logic pclk;
        analog = 8'h3C;
        @(negedge CLK_50M) sample_start = 1'b1;
        @(negedge CLK_50M) sample_start = 1'b0;
        pclk = AD_CLK;
        for (k = 0; k < WAIT_MAX && nr < 4; k++) begin
            @(negedge CLK_50M);
            if (!pclk && AD_CLK) nr++;
            pclk = AD_CLK;
        end
        n_cmp++;
        if (nr != 4) begin n_bad++; $display("FAIL mid_rises: %0d rises seen required 4", nr); end
        repeat (5) @(negedge CLK_50M);
        p0 = npulse;
        enter_reset();
        #1;
        n_cmp += 3;
        if (AD_CS !== 1'b1)  begin n_bad++; $display("FAIL mid_rst_cs: AD_CS=%b required 1", AD_CS); end
        if (AD_CLK !== 1'b0) begin n_bad++; $display("FAIL mid_rst_clk: AD_CLK=%b required 0", AD_CLK); end
        if (busy !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_busy: busy=%b required 0", busy); end
        repeat (3) @(negedge CLK_50M);
        RST_N = 1'b1;
        repeat (50) @(negedge CLK_50M);
        n_cmp++;
        if (npulse != p0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL mid_no_valid: %0d pulses busy=%b required 0/0", npulse - p0, busy); end
        run_frame();
        n_cmp++;
        if (npulse != p0) begin n_bad++; $display("FAIL mid_first_drop: %0d pulses required 0", npulse - p0); end
        run_frame();
        n_cmp += 2;
        if (npulse - p0 != 1)  begin n_bad++; $display("FAIL mid_second: %0d pulses required 1", npulse - p0); end
        if (ad_data !== 8'h3C) begin n_bad++; $display("FAIL mid_data: ad_data=%h required 3c", ad_data); end
    endtask

    task automatic test_values();
        logic [7:0] vals[4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
        int p0;
        p0 = npulse;
        foreach (vals[i]) begin
            analog = vals[i];
            run_frame();
        end
        analog = 8'h5A;
        run_frame();
        n_cmp += 3;
        if (npulse - p0 != 5)  begin n_bad++; $display("FAIL values_count: %0d pulses required 5", npulse - p0); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL values_queue: %0d outstanding required 0", exp_q.size()); end
        if (ad_data !== 8'h01) begin n_bad++; $display("FAIL values_last: ad_data=%h required 01", ad_data); end
    endtask
`else
    task automatic test_auto();
        int   nf = 0, p0, f[3];
        logic pcs;
        p0 = npulse;
        analog = 8'hC3;
        pcs = AD_CS;
        for (int i = 0; i < 3 * FRAME + 200 && nf < 3; i++) begin
            @(negedge CLK_50M);
            if (pcs && !AD_CS) begin f[nf] = i; nf++; end
            pcs = AD_CS;
        end
        n_cmp += 4;
        if (nf != 3) begin n_bad++; $display("FAIL auto_frames: %0d CS falls required 3", nf); end
        if (f[1] - f[0] != FRAME) begin n_bad++; $display("FAIL auto_period1: %0d required %0d", f[1] - f[0], FRAME); end
        if (f[2] - f[1] != FRAME) begin n_bad++; $display("FAIL auto_period2: %0d required %0d", f[2] - f[1], FRAME); end
        if (npulse - p0 != 1) begin n_bad++; $display("FAIL auto_pulses: %0d required 1", npulse - p0); end
    endtask
`endif

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifdef ADC_AUTO_EN
        test_auto();
`else
        test_first_frame();
        test_timing();
        test_busy_ignore();
        test_reset_midframe();
        test_values();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
